// File: rtl/cmos_crop_stream.sv
// cmos_crop_stream: crops the Bayer pixel stream from the depacketizer to the
// output window. Kept pixels are re-emitted as a ready/valid stream with SOF
// (tuser) and EOL (tlast) tags, buffered by a first-word fall-through FIFO.
// Also checks line/frame geometry, reports drops, and counts completed frames.
module cmos_crop_stream #(
   parameter int unsigned IN_H       = 1922,
   parameter int unsigned IN_V       = 1082,
   parameter int unsigned CROP_X     = 1,
   parameter int unsigned CROP_Y     = 1,
   parameter int unsigned OUT_H      = 1920,
   parameter int unsigned OUT_V      = 1080,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        I_CLK,
   input  logic        I_Rst_n,
   input  logic [7:0]  I_Cmos_Pixel,
   input  logic        I_Cmos_Vaild,
   input  logic        I_Cmos_V_Sync,
   input  logic        I_Clr_Err,
   output logic [7:0]  O_Tdata,
   output logic        O_Tvalid,
   input  logic        I_Tready,
   output logic        O_Tuser,
   output logic        O_Tlast,
   output logic        O_Overflow,
   output logic        O_Frame_Err,
   output logic [15:0] O_Frame_Cnt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   localparam logic [11:0] LP_X0   = 12'(CROP_X);
   localparam logic [11:0] LP_X1   = 12'(CROP_X + OUT_H);
   localparam logic [11:0] LP_XL   = 12'(CROP_X + OUT_H - 1);
   localparam logic [11:0] LP_Y0   = 12'(CROP_Y);
   localparam logic [11:0] LP_Y1   = 12'(CROP_Y + OUT_V);
   localparam logic [11:0] LP_IN_H = 12'(IN_H);
   localparam logic [11:0] LP_IN_V = 12'(IN_V);

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DROP} state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [7:0]    r_pix;
   logic          r_vld;
   logic          r_vs;
   logic          r_vld_d;
   logic          r_vs_d;
   logic [11:0]   r_x;
   logic [11:0]   r_y;
   logic          r_ovf;
   logic          r_err;
   logic [15:0]   r_frame_cnt;

   logic [9:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic          w_vs_rise;
   logic          w_vld_fall;
   logic [11:0]   w_y;
   logic [11:0]   w_y_end;
   logic          w_keep;
   logic          w_tuser;
   logic          w_tlast;
   logic          w_full;
   logic          w_empty;
   logic          w_rd;
   logic          w_try;
   logic          w_wr;
   logic          w_drop;
   logic          w_close;
   logic          w_line_err;
   logic          w_frame_bad;
   logic [9:0]    w_head;

   // Register the raw inputs once, then keep one more stage of sync/valid for edge detection
   always_ff @(posedge I_CLK) begin
      if (!I_Rst_n) begin
         r_pix   <= '0;
         r_vld   <= 1'b0;
         r_vs    <= 1'b0;
         r_vld_d <= 1'b0;
         r_vs_d  <= 1'b0;
      end else begin
         r_pix   <= I_Cmos_Pixel;
         r_vld   <= I_Cmos_Vaild;
         r_vs    <= I_Cmos_V_Sync;
         r_vld_d <= r_vld;
         r_vs_d  <= r_vs;
      end
   end

   assign w_vs_rise  = r_vs & ~r_vs_d;
   assign w_vld_fall = r_vld_d & ~r_vld;

   // A pixel arriving with the sync rise is row 0 of the new frame
   assign w_y     = w_vs_rise ? '0 : r_y;
   // Row count at frame close, including a line that ends in the same cycle
   assign w_y_end = w_vld_fall ? r_y + 12'd1 : r_y;

   assign w_keep  = r_vld && (r_x >= LP_X0) && (r_x < LP_X1) && (w_y >= LP_Y0) && (w_y < LP_Y1);
   assign w_tuser = (r_x == LP_X0) && (w_y == LP_Y0);
   assign w_tlast = (r_x == LP_XL);

   // Column and row position counters
   always_ff @(posedge I_CLK) begin
      if (!I_Rst_n) begin
         r_x <= '0;
         r_y <= '0;
      end else begin
         if (w_vld_fall) begin
            r_x <= '0;
         end else if (r_vld) begin
            r_x <= r_x + 12'd1;
         end
         if (w_vs_rise) begin
            r_y <= '0;
         end else if (w_vld_fall) begin
            r_y <= r_y + 12'd1;
         end
      end
   end

   assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_rd    = ~w_empty & I_Tready;

   // FSM state register
   always_ff @(posedge I_CLK) begin
      if (!I_Rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: a sync rise opens a frame unless its own pixel is dropped
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_vs_rise) w_state_nxt = w_drop ? ST_DROP : ST_ACTIVE;
         ST_ACTIVE: if (w_drop)    w_state_nxt = ST_DROP;
         ST_DROP:   if (w_vs_rise) w_state_nxt = w_drop ? ST_DROP : ST_ACTIVE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: write kept pixels while a frame is open, drop when the FIFO cannot take them
   always_comb begin
      w_try       = w_keep & ((r_state == ST_ACTIVE) | w_vs_rise);
      w_wr        = w_try & (~w_full | w_rd);
      w_drop      = w_try & w_full & ~w_rd;
      w_close     = w_vs_rise & (r_state != ST_IDLE);
      w_line_err  = w_vld_fall & (r_state != ST_IDLE) & (r_x != LP_IN_H);
      w_frame_bad = w_close & (w_y_end != LP_IN_V);
   end

   // Sticky status flags (set beats clear) and completed-frame counter
   always_ff @(posedge I_CLK) begin
      if (!I_Rst_n) begin
         r_ovf       <= 1'b0;
         r_err       <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (I_Clr_Err) begin
            r_ovf <= 1'b0;
         end
         if (w_line_err || w_frame_bad) begin
            r_err <= 1'b1;
         end else if (I_Clr_Err) begin
            r_err <= 1'b0;
         end
         if (w_close) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge I_CLK) begin
      if (!I_Rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage, {tuser, tlast, pixel}
   always_ff @(posedge I_CLK) begin
      if (w_wr) r_mem[r_wr_ptr] <= {w_tuser, w_tlast, r_pix};
   end

   assign w_head      = r_mem[r_rd_ptr];
   assign O_Tvalid    = ~w_empty;
   assign O_Tdata     = w_empty ? '0 : w_head[7:0];
   assign O_Tlast     = ~w_empty & w_head[8];
   assign O_Tuser     = ~w_empty & w_head[9];
   assign O_Overflow  = r_ovf;
   assign O_Frame_Err = r_err;
   assign O_Frame_Cnt = r_frame_cnt;

endmodule

// File: tb/tb_cmos_crop_stream.sv
// tb_cmos_crop_stream: scoreboard bench for cmos_crop_stream on a small 8x6 frame.
// Stimulus tasks push the expected output words (from the crop rule) into a queue;
// a monitor pops and compares on every accepted output word.
module tb_cmos_crop_stream;

   localparam int IN_H = 8;
   localparam int IN_V = 6;
   localparam int CX   = 1;
   localparam int CY   = 1;
   localparam int OH   = 6;
   localparam int OV   = 4;
   localparam int FD   = 4;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic [7:0]  pix    = '0;
   logic        vld    = 1'b0;
   logic        vs     = 1'b0;
   logic        clr    = 1'b0;
   logic        tready = 1'b1;
   logic [7:0]  O_Tdata;
   logic        O_Tvalid;
   logic        O_Tuser;
   logic        O_Tlast;
   logic        O_Overflow;
   logic        O_Frame_Err;
   logic [15:0] O_Frame_Cnt;

   always #5 clk = ~clk;

   cmos_crop_stream #(
      .IN_H(IN_H), .IN_V(IN_V), .CROP_X(CX), .CROP_Y(CY),
      .OUT_H(OH), .OUT_V(OV), .FIFO_DEPTH(FD)
   ) dut (
      .I_CLK(clk), .I_Rst_n(rst_n), .I_Cmos_Pixel(pix), .I_Cmos_Vaild(vld),
      .I_Cmos_V_Sync(vs), .I_Clr_Err(clr), .O_Tdata(O_Tdata), .O_Tvalid(O_Tvalid),
      .I_Tready(tready), .O_Tuser(O_Tuser), .O_Tlast(O_Tlast),
      .O_Overflow(O_Overflow), .O_Frame_Err(O_Frame_Err), .O_Frame_Cnt(O_Frame_Cnt)
   );

   logic [9:0] exp_q [$];
   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   bit exp_err = 0;
   bit exp_ovf = 0;
   bit first_frame = 1;
   int prev_lines = 0;
   int kept = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit keep(input int c, input int r);
      return (c >= CX) && (c < CX + OH) && (r >= CY) && (r < CY + OV);
   endfunction

   // Monitor: compare every accepted word; check data holds while stalled
   logic [9:0] prev_word = '0;
   bit         prev_stall = 0;
   always @(negedge clk) begin
      logic [9:0] w;
      logic [9:0] e;
      w = {O_Tuser, O_Tlast, O_Tdata};
      if (prev_stall) chk("hold_while_stalled", {O_Tvalid, w}, {1'b1, prev_word});
      prev_stall = O_Tvalid && !tready && rst_n;
      prev_word  = w;
      if (O_Tvalid && tready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got 0x%0h, expected no output (t=%0t)", w, $time);
         end else begin
            e = exp_q.pop_front();
            chk("word", w, e);
         end
      end
   end

   task automatic start_frame(input int nlines);
      @(posedge clk); #1 vs = 1'b1;
      @(posedge clk); #1 vs = 1'b0;
      if (!first_frame) begin
         exp_cnt = (exp_cnt + 1) & 16'hFFFF;
         if (prev_lines != IN_V) exp_err = 1;
      end
      first_frame = 0;
      prev_lines  = nlines;
      kept        = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("frame_cnt", O_Frame_Cnt, exp_cnt);
      chk("frame_err_at_sync", O_Frame_Err, exp_err);
      chk("overflow_at_sync", O_Overflow, exp_ovf);
   endtask

   task automatic drive_line(input int r, input int len, input bit ramp, input bit ctl_ready,
                             input int st, input int sl, input int keep_max);
      logic tu;
      logic tl;
      for (int c = 0; c < len; c++) begin
         @(posedge clk); #1;
         vld = 1'b1;
         pix = ramp ? 8'(16 * r + c) : 8'($urandom);
         if (ctl_ready) tready = !((c >= st) && (c < st + sl));
         if (keep(c, r)) begin
            tu = (c == CX) && (r == CY);
            tl = (c == CX + OH - 1);
            if (keep_max < 0 || kept < keep_max) exp_q.push_back({tu, tl, pix});
            kept++;
         end
      end
      @(posedge clk); #1;
      vld = 1'b0;
      pix = '0;
      if (ctl_ready) tready = 1'b1;
      repeat (6) @(posedge clk);
      if (len != IN_H) exp_err = 1;
      @(negedge clk);
      chk("frame_err_after_line", O_Frame_Err, exp_err);
   endtask

   // mode 0: leave tready alone, 1: random short stalls per line, 2: 3-cycle stall mid row 2
   task automatic send_frame(input int nlines, input int bad_row, input bit ramp,
                             input int mode, input int keep_max);
      int len;
      int st;
      int sl;
      bit ctl;
      start_frame(nlines);
      for (int r = 0; r < nlines; r++) begin
         len = (r == bad_row) ? IN_H - 1 : IN_H;
         ctl = 0; st = 0; sl = 0;
         if (mode == 1) begin
            ctl = 1;
            st  = $urandom_range(0, 7);
            sl  = $urandom_range(0, 3);
         end else if (mode == 2 && r == 2) begin
            ctl = 1; st = 3; sl = 3;
         end
         drive_line(r, len, ramp, ctl, st, sl, keep_max);
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || O_Tvalid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_words_left"}, exp_q.size(), 0);
      chk({name, "_tvalid_idle"}, O_Tvalid, 0);
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      exp_err = 0;
      exp_ovf = 0;
      @(negedge clk);
      chk("clr_overflow", O_Overflow, 0);
      chk("clr_frame_err", O_Frame_Err, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", O_Tvalid, 0);
      chk("rst_tdata", O_Tdata, 0);
      chk("rst_tuser", O_Tuser, 0);
      chk("rst_tlast", O_Tlast, 0);
      chk("rst_overflow", O_Overflow, 0);
      chk("rst_frame_err", O_Frame_Err, 0);
      chk("rst_frame_cnt", O_Frame_Cnt, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // nominal ramp frame, then backpressure frame
      send_frame(6, -1, 1, 0, -1);
      wait_drain("nominal");
      send_frame(6, -1, 1, 2, -1);
      wait_drain("backpressure");
      chk("backpressure_no_overflow", O_Overflow, 0);

      // random data with random short stalls
      for (int i = 0; i < 3; i++) begin
         send_frame(6, -1, 0, 1, -1);
         wait_drain("random");
      end

      // overflow: consumer stalled for a whole frame
      tready = 1'b0;
      send_frame(6, -1, 1, 0, FD);
      exp_ovf = 1;
      @(negedge clk);
      chk("overflow_set", O_Overflow, 1);
      chk("overflow_fifo_held", O_Tvalid, 1);
      @(posedge clk); #1 tready = 1'b1;
      wait_drain("overflow_release");
      send_frame(6, -1, 1, 0, -1);
      wait_drain("after_overflow");
      pulse_clr();

      // geometry: short line, then short frame detected at the next sync
      send_frame(6, 3, 1, 0, -1);
      wait_drain("short_line");
      pulse_clr();
      send_frame(5, -1, 1, 0, -1);
      wait_drain("short_frame");
      send_frame(6, -1, 0, 0, -1);
      wait_drain("after_short_frame");
      pulse_clr();

      // reset in the middle of row 3 with words pending
      start_frame(6);
      for (int r = 0; r < 3; r++) drive_line(r, IN_H, 1, 0, 0, 0, -1);
      tready = 1'b0;
      for (int c = 0; c < IN_H; c++) begin
         @(posedge clk); #1;
         vld = 1'b1;
         pix = 8'(48 + c);
         if (c < 3 && keep(c, 3)) exp_q.push_back({1'b0, 1'b0, pix});
         if (c == 3) begin
            rst_n = 1'b0;
            exp_q.delete();
            first_frame = 1;
            exp_cnt = 0;
            exp_err = 0;
            exp_ovf = 0;
         end
         if (c == 5) rst_n = 1'b1;
         if (c == 3) begin
            @(negedge clk);
            chk("pre_reset_nonempty", O_Tvalid, 1);
         end
         if (c == 4) begin
            @(negedge clk);
            chk("mid_reset_tvalid", O_Tvalid, 0);
            chk("mid_reset_frame_cnt", O_Frame_Cnt, 0);
         end
      end
      @(posedge clk); #1;
      vld = 1'b0;
      tready = 1'b1;
      for (int r = 4; r < 6; r++) drive_line(r, IN_H, 1, 0, 0, 0, 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("post_reset_silent", O_Tvalid, 0);
      send_frame(6, -1, 1, 0, -1);
      wait_drain("after_reset");

      // frame counter wrap
      @(negedge clk);
      force dut.r_frame_cnt = 16'hFFFF;
      @(posedge clk); #1;
      release dut.r_frame_cnt;
      exp_cnt = 16'hFFFF;
      @(negedge clk);
      chk("cnt_preload", O_Frame_Cnt, 16'hFFFF);
      send_frame(6, -1, 1, 0, -1);
      wait_drain("wrap");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmos_crop_stream.md
# cmos_crop_stream

Downstream stage of the IMX222 depacketizer. It takes the Bayer pixel stream (pixel, valid, frame sync) and crops the 1922×1082 active window to the 1920×1080 image. It re-emits the result as a ready/valid stream with start-of-frame and end-of-line tags, decoupled by a small FIFO. It also checks line and frame geometry and reports drops.

## Interface
Parameters:
- IN_H, 1922, valid pixels per input line
- IN_V, 1082, valid lines per input frame
- CROP_X, 1, first kept column (0-based)
- CROP_Y, 1, first kept row (0-based)
- OUT_H, 1920, kept columns; CROP_X+OUT_H ≤ IN_H
- OUT_V, 1080, kept rows; CROP_Y+OUT_V ≤ IN_V
- FIFO_DEPTH, 16, output FIFO entries, power of two ≥ 4

Ports (one clock; reset is synchronous and active-low):
- I_CLK  in  1  pixel clock, all logic on rising edge
- I_Rst_n  in  1  synchronous active-low reset
- I_Cmos_Pixel  in  8  Bayer pixel, meaningful when I_Cmos_Vaild=1
- I_Cmos_Vaild  in  1  high for each valid pixel of a line, contiguous per line
- I_Cmos_V_Sync  in  1  frame sync; its rising edge marks a new frame
- I_Clr_Err  in  1  single-cycle pulse, clears sticky error flags
- O_Tdata  out  8  output pixel
- O_Tvalid  out  1  O_Tdata/O_Tuser/O_Tlast valid
- I_Tready  in  1  consumer accepts the word when O_Tvalid & I_Tready
- O_Tuser  out  1  first pixel of frame (SOF)
- O_Tlast  out  1  last pixel of line (EOL)
- O_Overflow  out  1  sticky, a pixel was dropped because the FIFO was full
- O_Frame_Err  out  1  sticky, line length or line count mismatch
- O_Frame_Cnt  out  16  completed frames, wraps 0xFFFF→0

## Operation
- The input stage registers pixel, valid and sync once, then runs edge detection on the registered sync and valid.
- Column counter x (12 bit):
  - Increments per registered valid pixel.
  - Cleared on the valid falling edge.
- Row counter y (12 bit):
  - Increments on each valid falling edge.
  - Cleared on sync rise.
- Keep rule: a pixel is kept iff CROP_X ≤ x < CROP_X+OUT_H and CROP_Y ≤ y < CROP_Y+OUT_V, where x and y are the values before the increment.
- Tags on kept pixels:
  - tuser = (x==CROP_X && y==CROP_Y)
  - tlast = (x==CROP_X+OUT_H−1)
- A kept pixel pushes the 10-bit word {tuser, tlast, data} into the FIFO.
- State machine:
  - IDLE: no writes. Sync rise → ACTIVE.
  - ACTIVE: writes kept pixels.
    - A write attempt with FIFO full and no read in the same cycle → the pixel is dropped, O_Overflow←1, go to DROP.
    - Sync rise → ACTIVE, with a frame close (below).
  - DROP: no writes for the rest of the frame. Sync rise → ACTIVE, with a frame close.
- Frame close, applied at every sync rise except the first after reset:
  - If y ≠ IN_V, set O_Frame_Err.
  - O_Frame_Cnt += 1.
- Line check: at each valid falling edge, x ≠ IN_H sets O_Frame_Err (this applies in DROP as well).
- I_Clr_Err clears O_Overflow and O_Frame_Err. A set event in the same cycle wins.
- FIFO behaviour:
  - First-word fall-through.
  - A write while full is allowed only if a read happens in the same cycle.
  - A read and a write in the same cycle leave the count unchanged.
  - Contents drain independently of state. A sync rise never flushes the FIFO.

## Timing
- Reset values:
  - State = IDLE, FIFO empty, x = y = 0.
  - O_Tvalid, O_Tuser, O_Tlast, O_Overflow, O_Frame_Err = 0; O_Tdata = 0; O_Frame_Cnt = 0.
- Reset asserted mid-frame discards FIFO contents and the partial frame. Output resumes only with the SOF of the next full frame.
- Latency: a kept input pixel at cycle n → FIFO write at n+1 → O_Tvalid at n+2 (FIFO empty).
- Handshake:
  - Once O_Tvalid is asserted, O_Tdata and the tags hold until accepted.
  - O_Tvalid falls only after acceptance of the last entry.
- Sync edge detection adds 1 cycle. A sync rise coincident with a valid pixel belongs to the new frame.
- Throughput: 1 pixel/cycle sustained while I_Tready=1; no overflow ever occurs in that case.

## Test plan
Sim parameters: IN_H=8, IN_V=6, CROP_X=1, CROP_Y=1, OUT_H=6, OUT_V=4, FIFO_DEPTH=4.
- Nominal frame: sync rise, then 6 lines of 8 pixels with value = 16·row+col, I_Tready=1 → 24 words:
  - first word 0x11 with tuser=1;
  - tlast on 0x16, 0x26, 0x36, 0x46;
  - last word 0x46.
  - On the next sync rise: O_Frame_Cnt 0→1, O_Frame_Err=0.
- Backpressure: I_Tready low for 3 cycles in mid-line 2 → no drop, all 24 words in order, O_Overflow=0.
- Overflow: I_Tready=0 for a whole frame → 4 words buffered (0x11..0x14), O_Overflow=1, DROP entered.
  - Releasing I_Tready yields exactly those 4 words.
  - The next frame's SOF 0x11 follows normally.
- Geometry errors:
  - A 7-pixel line → O_Frame_Err=1 at that line's valid fall.
  - After I_Clr_Err, a 5-line frame → O_Frame_Err=1 at the next sync rise.
- Reset mid-frame: I_Rst_n=0 for 2 cycles during row 3 with the FIFO non-empty → O_Tvalid=0 next cycle, O_Frame_Cnt=0.
  - No output until the next sync rise; then the full 24-word frame is produced.
- Counter wrap: preload 0xFFFF frames via forced completions → the next close gives O_Frame_Cnt=0.
